// File: rtl/match_bundle_packer_if.sv
// Handshake bundle for match_bundle_packer: a serial word stream in, a LANES-wide
// bundle stream out. The packer uses the slave view and its feeder uses the master view.
interface match_bundle_packer_if #(
  parameter int WIDTH = 10,
  parameter int LANES = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic                   in_last;
  logic                   flush;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH*LANES-1:0] out_data;
  logic [LANES-1:0]       out_mask;
  logic                   out_last;

  modport master (
    output in_valid, in_data, in_last, flush, out_ready,
    input  in_ready, out_valid, out_data, out_mask, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, flush, out_ready,
    output in_ready, out_valid, out_data, out_mask, out_last
  );
endinterface

// File: rtl/match_bundle_packer.sv
// Packs a serial stream of candidate words into LANES-wide bundles behind a
// one-entry output register. A second closed bundle may wait in the accumulator (HOLD).
module match_bundle_packer #(
  parameter int WIDTH = 10,
  parameter int LANES = 4,
  parameter int CNTW  = 16
) (
  input  logic                   clk,
  input  logic                   reset_l,
  match_bundle_packer_if.slave   bus,
  output logic [CNTW-1:0]        bundle_cnt
);

  localparam int IDXW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDXW-1:0] IDX_MAX = IDXW'(LANES - 1);

  typedef enum logic {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t                        r_state;
  logic [IDXW-1:0]               r_idx;
  logic [LANES-1:0][WIDTH-1:0]   r_acc;
  logic [LANES-1:0]              r_acc_mask;
  logic                          r_acc_last;

  logic                          r_out_valid;
  logic [LANES-1:0][WIDTH-1:0]   r_out_data;
  logic [LANES-1:0]              r_out_mask;
  logic                          r_out_last;
  logic [CNTW-1:0]               r_cnt;

  logic                          w_in_ready;
  logic                          w_accept;
  logic                          w_drain;
  logic                          w_out_free;
  logic                          w_close;
  logic [LANES-1:0][WIDTH-1:0]   w_acc_n;
  logic [LANES-1:0]              w_mask_n;
  logic                          w_last_n;

  // Ready depends only on state (and reset), never on in_valid, so the
  // upstream may build its valid from ready without forming a loop.
  assign w_in_ready = (r_state == S_FILL) && reset_l;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_drain    = r_out_valid && bus.out_ready;
  assign w_out_free = !r_out_valid || w_drain;

  // Accumulator contents as they would look after this cycle's beat.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which is what keeps a combinational block from inferring a latch.
    w_acc_n  = r_acc;
    w_mask_n = r_acc_mask;
    w_last_n = r_acc_last;
    if (w_accept) begin
      w_acc_n[r_idx]  = bus.in_data;
      w_mask_n[r_idx] = 1'b1;
      w_last_n        = r_acc_last | bus.in_last;
    end
  end

  // A flush only closes a bundle that has (or is just getting) at least one word.
  always_comb begin
    w_close = 1'b0;
    if (r_state == S_FILL) begin
      w_close = (w_accept && ((r_idx == IDX_MAX) || bus.in_last))
             || (bus.flush && ((r_idx != '0) || w_accept));
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    // NOTE: the accumulator is a handful of flops, not a RAM, so it is cleared
    // on reset to guarantee a partial bundle never leaks past a reset.
    if (!reset_l) begin
      r_state     <= S_FILL;
      r_idx       <= '0;
      r_acc       <= '0;
      r_acc_mask  <= '0;
      r_acc_last  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_mask  <= '0;
      r_out_last  <= 1'b0;
      r_cnt       <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop sees
      // pre-edge values regardless of statement order.
      if (w_drain) begin
        r_cnt <= r_cnt + 1'b1;
      end

      unique case (r_state)
        S_FILL: begin
          if (w_close && w_out_free) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_acc_n;
            r_out_mask  <= w_mask_n;
            r_out_last  <= w_last_n;
            r_acc       <= '0;
            r_acc_mask  <= '0;
            r_acc_last  <= 1'b0;
            r_idx       <= '0;
          end else if (w_close) begin
            // Output register still occupied: park the closed bundle here.
            r_acc      <= w_acc_n;
            r_acc_mask <= w_mask_n;
            r_acc_last <= w_last_n;
            r_state    <= S_HOLD;
          end else begin
            if (w_accept) begin
              r_acc      <= w_acc_n;
              r_acc_mask <= w_mask_n;
              r_acc_last <= w_last_n;
              r_idx      <= r_idx + IDXW'(1);
            end
            if (w_drain) begin
              r_out_valid <= 1'b0;
            end
          end
        end

        S_HOLD: begin
          if (w_drain) begin
            r_out_data <= r_acc;
            r_out_mask <= r_acc_mask;
            r_out_last <= r_acc_last;
            r_acc      <= '0;
            r_acc_mask <= '0;
            r_acc_last <= 1'b0;
            r_idx      <= '0;
            r_state    <= S_FILL;
          end
        end

        default: begin
          r_state <= S_FILL;
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_mask  = r_out_mask;
  assign bus.out_last  = r_out_last;
  assign bundle_cnt    = r_cnt;

endmodule
